// File: rtl/reorder_buf.sv
// rtl/reorder_buf.sv - 8-entry in-order reorder buffer with tag rename, CDB capture and registered commit
module reorder_buf #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             alloc_req,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ok,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             en_mod0,
  output logic [4:0]       reg_addr0,
  output logic [TAG_W-1:0] reg_tag0,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             en_w0,
  output logic [4:0]       reg_write_addr0,
  output logic [31:0]      write_data0,
  output logic [TAG_W-1:0] commit_tag,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [3:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] UNLOCKED = TAG_W'(DEPTH);
  localparam logic [3:0] CNT_MAX = 4'(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [4:0]       rd   [DEPTH];
  logic [31:0]      data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             fire;
  logic             commit_fire;
  logic             cdb_hit;
  logic [PTR_W-1:0] cdb_idx;
  logic             advance;

  assign alloc_ok  = (count < CNT_MAX) & ~flush & rdy;
  assign full      = (count == CNT_MAX);
  assign empty     = (count == 4'd0);
  assign alloc_tag = {{(TAG_W-PTR_W){1'b0}}, tail};

  assign fire      = alloc_req & alloc_ok;
  assign en_mod0   = fire & (alloc_rd != 5'd0);
  assign reg_addr0 = alloc_rd;
  assign reg_tag0  = alloc_tag;

  // A freshly allocated tail entry is still invalid here, so same-cycle CDB to it is dropped.
  assign cdb_idx     = cdb_tag[PTR_W-1:0];
  assign cdb_hit     = cdb_valid & (cdb_tag < UNLOCKED) & valid[cdb_idx];
  assign commit_fire = valid[head] & ready[head];
  assign advance     = rdy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid           <= '0;
      ready           <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      en_w0           <= 1'b0;
      reg_write_addr0 <= '0;
      write_data0     <= '0;
      commit_tag      <= UNLOCKED;
    end else if (rdy) begin
      if (flush) begin
        valid <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        en_w0 <= 1'b0;
      end else begin
        en_w0 <= 1'b0;
        if (cdb_hit) begin
          ready[cdb_idx] <= 1'b1;
        end
        if (commit_fire) begin
          valid[head]     <= 1'b0;
          head            <= head + PTR_W'(1);
          en_w0           <= (rd[head] != 5'd0);
          reg_write_addr0 <= rd[head];
          write_data0     <= data[head];
          commit_tag      <= {{(TAG_W-PTR_W){1'b0}}, head};
        end
        if (fire) begin
          valid[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + PTR_W'(1);
        end
        count <= count + {3'b0, fire} - {3'b0, commit_fire};
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/ready.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (cdb_hit) begin
        data[cdb_idx] <= cdb_data;
      end
      if (fire) begin
        rd[tail] <= alloc_rd;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buf.sv
// tb/tb_reorder_buf.sv - randomized and directed bench for reorder_buf against an in-order queue model
module tb_reorder_buf;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        alloc_req;
  logic [4:0]  alloc_rd;
  logic        alloc_ok;
  logic [3:0]  alloc_tag;
  logic        en_mod0;
  logic [4:0]  reg_addr0;
  logic [3:0]  reg_tag0;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        en_w0;
  logic [4:0]  reg_write_addr0;
  logic [31:0] write_data0;
  logic [3:0]  commit_tag;
  logic        flush;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  reorder_buf dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_ok(alloc_ok), .alloc_tag(alloc_tag),
    .en_mod0(en_mod0), .reg_addr0(reg_addr0), .reg_tag0(reg_tag0),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .en_w0(en_w0), .reg_write_addr0(reg_write_addr0), .write_data0(write_data0),
    .commit_tag(commit_tag), .flush(flush),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: program-order queue of in-flight tags plus per-tag payload.
  int          q[$];
  int          m_tail;
  bit          m_ready [8];
  bit [4:0]    m_rd    [8];
  bit [31:0]   m_data  [8];
  bit          m_en_w;
  bit [4:0]    m_waddr;
  bit [31:0]   m_wdata;
  bit [3:0]    m_ctag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    m_en_w  = 0;
    m_waddr = 0;
    m_wdata = 0;
    m_ctag  = 4'd8;
  endtask

  // Called at posedge+1: drive, check before the edge, advance the model across the edge.
  task automatic step(input bit areq, input bit [4:0] ard, input bit cv, input bit [3:0] ct,
                      input bit [31:0] cd, input bit fl, input bit r);
    bit e_aok, e_fire, commit, hit;
    int cnt, h;
    alloc_req = areq; alloc_rd = ard; cdb_valid = cv; cdb_tag = ct;
    cdb_data = cd; flush = fl; rdy = r;
    #4;
    cnt    = q.size();
    e_aok  = (cnt < 8) && !fl && r;
    e_fire = areq && e_aok;
    check("alloc_ok", alloc_ok, e_aok);
    check("alloc_tag", alloc_tag, m_tail);
    check("en_mod0", en_mod0, e_fire && (ard != 0));
    check("reg_addr0", reg_addr0, ard);
    check("reg_tag0", reg_tag0, m_tail);
    check("count", count, cnt);
    check("full", full, cnt == 8);
    check("empty", empty, cnt == 0);
    check("en_w0", en_w0, m_en_w);
    check("reg_write_addr0", reg_write_addr0, m_waddr);
    check("write_data0", write_data0, m_wdata);
    check("commit_tag", commit_tag, m_ctag);
    @(posedge clk);
    if (r) begin
      if (fl) begin
        q.delete();
        m_tail = 0;
        m_en_w = 0;
      end else begin
        commit = (q.size() > 0) && m_ready[q[0]];
        hit    = cv && (ct < 8) && in_q(ct);
        if (commit) begin
          h       = q.pop_front();
          m_en_w  = (m_rd[h] != 0);
          m_waddr = m_rd[h];
          m_wdata = m_data[h];
          m_ctag  = 4'(h);
        end else begin
          m_en_w = 0;
        end
        if (hit) begin
          m_ready[ct] = 1'b1;
          m_data[ct]  = cd;
        end
        if (e_fire) begin
          q.push_back(m_tail);
          m_ready[m_tail] = 1'b0;
          m_rd[m_tail]    = ard;
          m_tail          = (m_tail + 1) % 8;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; alloc_req = 0; alloc_rd = 0; cdb_valid = 0;
    cdb_tag = 0; cdb_data = 0; flush = 0;
    model_reset();
    #12;
    check("rst_commit_tag", commit_tag, 4'd8);
    check("rst_en_w0", en_w0, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_alloc_ok", alloc_ok, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic latency: alloc N, CDB N+1, commit visible during N+3
    step(1, 5, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 32'hDEADBEEF, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("lat_en_w0", en_w0, 1'b1);
    check("lat_addr", reg_write_addr0, 5'd5);
    check("lat_data", write_data0, 32'hDEADBEEF);
    check("lat_tag", commit_tag, 4'd0);
    idle(2);

    // Out-of-order completion, in-order commit
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0, 1);
    step(0, 0, 1, 2, 32'h22, 0, 1);
    step(0, 0, 1, 1, 32'h11, 0, 1);
    step(0, 0, 1, 0, 32'h10, 0, 1);
    idle(4);

    // Fill to full, one pop, wrap of tail
    for (int i = 0; i < 8; i++) step(1, 5'(i + 8), 0, 0, 0, 0, 1);
    check("full_flag", full, 1'b1);
    step(1, 9, 1, 4'(m_tail == 0 ? q[0] : q[0]), 32'hA5A5, 0, 1);
    idle(1);
    step(1, 7, 0, 0, 0, 0, 1);
    idle(1);

    // rd=0 allocation: no rename, silent commit
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 1, 4'(q[0]), $urandom, 0, 1);
    idle(3);

    // Flush with a ready head, then CDB to a discarded tag
    for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 0, 0, 0, 0, 1);
    step(0, 0, 1, 4'(q[0]), 32'h55, 0, 1);
    step(1, 4, 1, 4'(q[1]), 32'h66, 1, 1);
    check("flush_empty", empty, 1'b1);
    step(0, 0, 1, 1, 32'h77, 0, 1);
    idle(2);

    // rdy low freezes everything
    step(1, 3, 0, 0, 0, 0, 1);
    step(1, 4, 1, 0, 32'h99, 0, 0);
    step(0, 0, 1, 0, 32'h98, 1, 0);
    idle(3);

    // Asynchronous reset with three entries in flight
    for (int i = 0; i < 3; i++) step(1, 5'(i + 2), 0, 0, 0, 0, 1);
    step(0, 0, 1, 4'(q[0]), 32'hBEEF, 0, 1);
    #2; rst_n = 1'b0; #1;
    check("async_en_w0", en_w0, 1'b0);
    check("async_count", count, 4'd0);
    check("async_ctag", commit_tag, 4'd8);
    model_reset();
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 6, 0, 0, 0, 0, 1);
    check("post_rst_ctag_hold", commit_tag, 4'd8);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit [3:0] ct;
      if (q.size() > 0 && $urandom_range(3, 0) != 0) ct = 4'(q[$urandom_range(q.size() - 1, 0)]);
      else ct = 4'($urandom_range(15, 0));
      step($urandom_range(2, 0) != 0, 5'($urandom_range(31, 0)), $urandom_range(1, 0) == 1,
           ct, $urandom, $urandom_range(60, 0) == 0, $urandom_range(9, 0) != 0);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 The parameter DEPTH SHALL be 8: the number of in-flight entries (fixed).
REQ-002 The parameter TAG_W SHALL be 4: the tag width; tags 0..7 name entries, and UNLOCKED = 4'd8.
REQ-003 The port clk SHALL be an input, 1 bit: the single clock; all state changes on posedge.
REQ-004 The port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 The port rdy SHALL be an input, 1 bit: global enable; when low, all state is frozen.
REQ-006 The port alloc_req SHALL be an input, 1 bit: the issue stage requests an entry.
REQ-007 The port alloc_rd SHALL be an input, 5 bits: destination register of the issuing instruction.
REQ-008 The port alloc_ok SHALL be an output, 1 bit: an entry is available this cycle.
REQ-009 The port alloc_tag SHALL be an output, 4 bits: tag assigned on allocation, equal to the tail index.
REQ-010 The ports en_mod0 (output, 1 bit), reg_addr0 (output, 5 bits) and reg_tag0 (output, 4 bits) SHALL form the tag-rename write to the register status file.
REQ-011 The ports cdb_valid (input, 1 bit), cdb_tag (input, 4 bits) and cdb_data (input, 32 bits) SHALL carry the result broadcast.
REQ-012 The ports en_w0 (output, 1 bit), reg_write_addr0 (output, 5 bits) and write_data0 (output, 32 bits) SHALL form the commit write to the register status file.
REQ-013 The port commit_tag SHALL be an output, 4 bits: tag of the entry committed via en_w0.
REQ-014 The port flush SHALL be an input, 1 bit: discard all entries.
REQ-015 The ports full (output, 1 bit), empty (output, 1 bit) and count (output, 4 bits) SHALL report occupancy, with count ranging 0..8.

Function
REQ-016 Each entry SHALL hold valid, ready, rd[4:0] and data[31:0]; head and tail SHALL be 3-bit pointers that wrap 7->0; count SHALL be a 4-bit register.
REQ-017 The outputs alloc_ok, full and empty SHALL be decoded as follows: alloc_ok = (count<8) & ~flush & rdy; full = (count==8); empty = (count==0); alloc_tag = {1'b0,tail}.
REQ-018 An allocation SHALL fire when alloc_req & alloc_ok; the entry is written at the posedge as valid=1, ready=0, rd=alloc_rd, and tail is incremented.
REQ-019 The rename write SHALL be combinational: en_mod0 = fire & (alloc_rd!=0); reg_addr0 = alloc_rd; reg_tag0 = alloc_tag.
REQ-020 When cdb_valid, cdb_tag<8 and entry[cdb_tag].valid, the entry SHALL be updated to ready=1 and data=cdb_data at the posedge.
REQ-021 A broadcast whose tag is UNLOCKED, out of range, or addresses an invalid entry SHALL be ignored.
REQ-022 A commit SHALL fire when entry[head].valid & entry[head].ready (registered ready only, no CDB bypass); it pops at most 1 entry per cycle, clears valid, and increments head.
REQ-023 The commit outputs SHALL be registered: in the cycle after a commit fire, en_w0 = (rd!=0), reg_write_addr0 = rd, write_data0 = data, commit_tag = the popped tag; otherwise en_w0 = 0.
REQ-024 Latency SHALL be as follows: allocate at cycle N, CDB at N+1 gives ready at N+2, commit fires at N+2, and en_w0 is high during N+3.
REQ-025 When allocate and commit fire in the same cycle, count SHALL be unchanged and both pointers advance; alloc_ok at count==8 stays 0 even if a commit fires that cycle.
REQ-026 A CDB write to the tail entry in the same cycle it is allocated SHALL NOT be possible, because that entry is invalid; the broadcast is ignored.
REQ-027 When flush is high (and rdy is high), at the posedge all valid SHALL be set to 0, head, tail and count set to 0, and en_w0 set to 0 the next cycle; allocation, commit and CDB in the same cycle are discarded.
REQ-028 When rdy is low, pointers, entries and count SHALL hold, en_mod0 = 0, and the registered commit outputs SHALL hold their values.
REQ-029 Commits SHALL occur strictly in allocation order regardless of CDB arrival order.

Reset
REQ-030 While rst_n is low (asynchronous assertion), the block SHALL hold: all valid=0 and ready=0, head=tail=0, count=0, en_w0=0, reg_write_addr0=0, write_data0=0, and commit_tag=UNLOCKED.
REQ-031 Consequently, after reset alloc_ok = rdy and empty=1.
REQ-032 Release of rst_n SHALL take effect at the next posedge with no extra idle cycle required.

Verification
REQ-033 Allocate rd=5 at cycle 0, then CDB tag 0 with data 0xDEADBEEF at cycle 1 -> en_w0=1, reg_write_addr0=5, write_data0=0xDEADBEEF, commit_tag=0 at cycle 3.
REQ-034 Allocate tags 0,1,2 (rd 1,2,3), then CDB in order 2,1,0 -> three commits in order 0,1,2 on consecutive cycles after tag 0 becomes ready.
REQ-035 Allocate 8 entries -> full=1, alloc_ok=0; CDB tag 0 -> one commit; the cycle after the pop, alloc_ok=1, and the new alloc_tag=0 (wrap).
REQ-036 Allocate rd=0 -> en_mod0=0; after CDB, the commit pops it with en_w0=0 and count decrements.
REQ-037 Fill 4 entries with tag 0 ready, assert flush -> next cycle count=0, empty=1, en_w0=0, and a following CDB to tag 1 is ignored.
REQ-038 Drive rst_n low between clock edges with 3 entries valid -> outputs reset immediately (en_w0=0, count=0), and the first allocate after release gets tag 0.
